blink_sched: RTL and testbench

Synchronous LED blink scheduler that replaces the ripple-divider chain with one shared free-running counter. The counter is time-shared between NCH LED channels, and each channel picks its own divide tap. Tap changes arrive through a per-channel req/ack handshake and pass through a round-robin arbiter. Each change is applied glitch-free at a counter wrap boundary.

---
 rtl/blink_sched_pkg.sv | 15 +
 rtl/blink_sched_rr_arbiter.sv | 42 ++++
 rtl/blink_sched.sv | 100 ++++++++++
 tb/tb_blink_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/blink_sched_pkg.sv
// Shared types and helpers for the blink scheduler (counter width, channel count, tap select).
package blink_sched_pkg;

  localparam int unsigned CNT_W_DEF = 27;
  localparam int unsigned NCH_DEF   = 4;
  localparam int unsigned SEL_W     = 5;

  typedef logic [SEL_W-1:0] sel_t;

  // Out-of-range taps collapse onto the slowest real tap.
  function automatic sel_t clamp_sel(input sel_t sel, input int unsigned cnt_w);
    return (32'(sel) >= cnt_w) ? SEL_W'(cnt_w - 1) : sel;
  endfunction

endpackage

// File: rtl/blink_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at the index after the last grant.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt_c
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;
  int unsigned      idx;

  // Walk the requesters in rotated order and take the first one asserted.
  always_comb begin
    gnt_c   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && (idx == i) && req[i]) begin
          gnt_c[i] = 1'b1;
          found    = 1'b1;
          ptr_nxt  = (i == N - 1) ? PTR_W'(0) : PTR_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else if (found) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/blink_sched.sv
// LED blink scheduler: one shared counter, per-channel divide taps updated via req/ack at wrap points.
// Optional wrap pulse output enabled by defining BLINK_SCHED_TICK_EN.
module blink_sched
  import blink_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NCH   = NCH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       cfg_req,
  input  logic [NCH*SEL_W-1:0] cfg_sel,
  output logic [NCH-1:0]       cfg_ack,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       led
`ifdef BLINK_SCHED_TICK_EN
  ,
  output logic                 tick
`endif
);

  logic [CNT_W-1:0] cnt;
  sel_t             act_sel  [NCH];
  sel_t             pend_sel [NCH];
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   elig_c;
  logic [NCH-1:0]   gnt_c;
  logic [NCH-1:0]   apply_c;
  sel_t             m;
  logic             ones;

  assign elig_c = cfg_req & ~pend & ~cfg_ack;
  assign busy   = pend;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (elig_c),
    .gnt_c (gnt_c)
  );

  // A pending tap lands when every counter bit up to the wider of the two taps is set,
  // so both taps are low right after the edge.
  always_comb begin
    apply_c = '0;
    m       = '0;
    ones    = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      m    = (act_sel[c] > pend_sel[c]) ? act_sel[c] : pend_sel[c];
      ones = 1'b1;
      for (int unsigned b = 0; b < CNT_W; b++) begin
        if ((SEL_W'(b) <= m) && !cnt[b]) ones = 1'b0;
      end
      apply_c[c] = en && pend[c] && ones;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      cfg_ack <= '0;
      pend    <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        act_sel[c]  <= SEL_W'(CNT_W - 1);
        pend_sel[c] <= SEL_W'(CNT_W - 1);
      end
    end else begin
      if (en) cnt <= cnt + CNT_W'(1);
      cfg_ack <= gnt_c;
      for (int unsigned c = 0; c < NCH; c++) begin
        if (gnt_c[c]) begin
          pend_sel[c] <= clamp_sel(cfg_sel[c*SEL_W +: SEL_W], CNT_W);
          pend[c]     <= 1'b1;
        end else if (apply_c[c]) begin
          act_sel[c] <= pend_sel[c];
          pend[c]    <= 1'b0;
        end
      end
    end
  end

  // Tap mux straight off registered state; no extra flop on led.
  always_comb begin
    led = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned b = 0; b < CNT_W; b++) begin
        if (act_sel[c] == SEL_W'(b)) led[c] = cnt[b];
      end
    end
  end

`ifdef BLINK_SCHED_TICK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick <= 1'b0;
    else      tick <= en && (cnt == '1);
  end
`endif

endmodule

// File: tb/tb_blink_sched.sv
// Directed bench for blink_sched at CNT_W=8, NCH=4 (tick checked when BLINK_SCHED_TICK_EN is defined).
module tb_blink_sched;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  cfg_req;
  logic [19:0] cfg_sel;
  logic [3:0]  cfg_ack;
  logic [3:0]  busy;
  logic [3:0]  led;
`ifdef BLINK_SCHED_TICK_EN
  logic        tick;
`endif

  blink_sched #(.CNT_W(8), .NCH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cfg_req (cfg_req),
    .cfg_sel (cfg_sel),
    .cfg_ack (cfg_ack),
    .busy    (busy),
    .led     (led)
`ifdef BLINK_SCHED_TICK_EN
    ,
    .tick    (tick)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic [19:0] sel;
    logic [3:0]  ack;
    logic [3:0]  busy;
  } vec_t;

  vec_t       tbl [18];
  int         n_cmp;
  int         n_fail;
  logic [7:0] mcnt;
  logic [2:0] mact [4];
  logic       exp_tick;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_led();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = mcnt[mact[c]];
    return r;
  endfunction

  // One clock: advance the bench counter model and land on the next falling edge.
  task automatic step();
    logic wrap;
    wrap = rst && en && (mcnt == 8'hFF);
    @(posedge clk);
    if (!rst) mcnt = 8'd0;
    else if (en) mcnt = mcnt + 8'd1;
    exp_tick = wrap;
    @(negedge clk);
  endtask

  task automatic check_all(input string name, input logic [3:0] ack, input logic [3:0] bsy);
    cmp({name, ".ack"},  32'(cfg_ack), 32'(ack));
    cmp({name, ".busy"}, 32'(busy),    32'(bsy));
    cmp({name, ".led"},  32'(led),     32'(exp_led()));
`ifdef BLINK_SCHED_TICK_EN
    cmp({name, ".tick"}, 32'(tick),    32'(exp_tick));
`endif
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      en      = tbl[i].en;
      cfg_req = tbl[i].req;
      cfg_sel = tbl[i].sel;
      step();
      check_all($sformatf("row%0d", i), tbl[i].ack, tbl[i].busy);
    end
  endtask

  task automatic run_until(input string name, input logic [7:0] target,
                           input logic [3:0] ack, input logic [3:0] bsy);
    for (int g = 0; g < 300 && mcnt != target; g++) begin
      step();
      check_all(name, ack, bsy);
    end
    if (mcnt != target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout, count at %0h expected %0h", name, mcnt, target);
    end
  endtask

  task automatic set_act(input logic [2:0] a3, input logic [2:0] a2,
                         input logic [2:0] a1, input logic [2:0] a0);
    mact[3] = a3; mact[2] = a2; mact[1] = a1; mact[0] = a0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; mcnt = 8'd0; exp_tick = 1'b0;
    set_act(3'd7, 3'd7, 3'd7, 3'd7);
    rst = 1'b0; en = 1'b0; cfg_req = 4'b0; cfg_sel = 20'b0;

    // burst after reset, counter frozen: acks in order 0..3
    tbl[0]  = '{1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},  4'b0001, 4'b0001};
    tbl[1]  = '{1'b0, 4'b1110, {5'd4, 5'd3, 5'd2, 5'd1},  4'b0010, 4'b0011};
    tbl[2]  = '{1'b0, 4'b1100, {5'd4, 5'd3, 5'd2, 5'd1},  4'b0100, 4'b0111};
    tbl[3]  = '{1'b0, 4'b1000, {5'd4, 5'd3, 5'd2, 5'd1},  4'b1000, 4'b1111};
    tbl[4]  = '{1'b0, 4'b0000, {5'd4, 5'd3, 5'd2, 5'd1},  4'b0000, 4'b1111};
    // second burst after pointer wrapped; ch0 asks for 15 (clamps to 7); ch1 re-requests while busy
    tbl[5]  = '{1'b0, 4'b1111, {5'd6, 5'd5, 5'd4, 5'd15}, 4'b0001, 4'b0001};
    tbl[6]  = '{1'b0, 4'b1110, {5'd6, 5'd5, 5'd4, 5'd15}, 4'b0010, 4'b0011};
    tbl[7]  = '{1'b0, 4'b1100, {5'd6, 5'd5, 5'd4, 5'd15}, 4'b0100, 4'b0111};
    tbl[8]  = '{1'b0, 4'b1000, {5'd6, 5'd5, 5'd4, 5'd15}, 4'b1000, 4'b1111};
    tbl[9]  = '{1'b0, 4'b0010, {5'd6, 5'd5, 5'd6, 5'd15}, 4'b0000, 4'b1111};
    // pointer sits at 2: ch2 wins over ch1
    tbl[10] = '{1'b0, 4'b0110, {5'd0, 5'd3, 5'd3, 5'd0},  4'b0100, 4'b0100};
    tbl[11] = '{1'b0, 4'b0010, {5'd0, 5'd3, 5'd3, 5'd0},  4'b0010, 4'b0110};
    tbl[12] = '{1'b0, 4'b0000, {5'd0, 5'd3, 5'd3, 5'd0},  4'b0000, 4'b0110};
    // after reset the pointer is back at 0
    tbl[13] = '{1'b0, 4'b1111, {5'd3, 5'd3, 5'd3, 5'd3},  4'b0001, 4'b0001};
    tbl[14] = '{1'b0, 4'b1110, {5'd3, 5'd3, 5'd3, 5'd3},  4'b0010, 4'b0011};
    tbl[15] = '{1'b0, 4'b1100, {5'd3, 5'd3, 5'd3, 5'd3},  4'b0100, 4'b0111};
    tbl[16] = '{1'b0, 4'b1000, {5'd3, 5'd3, 5'd3, 5'd3},  4'b1000, 4'b1111};
    tbl[17] = '{1'b0, 4'b0000, {5'd3, 5'd3, 5'd3, 5'd3},  4'b0000, 4'b1111};

    @(negedge clk);
    check_all("reset0", 4'b0000, 4'b0000);
    step();
    check_all("reset1", 4'b0000, 4'b0000);
    rst = 1'b1;

    run_rows(0, 4);

    // free run: all four pending taps land together on the full wrap
    en = 1'b1;
    run_until("wait_wrap1", 8'hFF, 4'b0000, 4'b1111);
    step();
    set_act(3'd4, 3'd3, 3'd2, 3'd1);
    check_all("apply1", 4'b0000, 4'b0000);
    run_until("fast_taps", 8'h20, 4'b0000, 4'b0000);

    en = 1'b0;
    run_rows(5, 9);
    for (int i = 0; i < 40; i++) begin
      step();
      check_all("frozen", 4'b0000, 4'b1111);
    end

    // release the counter: ch1/ch2 land at 0x3F, ch1's new request is taken one cycle later
    en = 1'b1;
    run_until("to_3f", 8'h3F, 4'b0000, 4'b1111);
    step();
    set_act(3'd4, 3'd5, 3'd4, 3'd1);
    check_all("apply_3f", 4'b0000, 4'b1001);
    step();
    check_all("reack_ch1", 4'b0010, 4'b1011);
    cfg_req = 4'b0000;
    run_until("to_7f", 8'h7F, 4'b0000, 4'b1011);
    step();
    set_act(3'd6, 3'd5, 3'd6, 3'd1);
    check_all("apply_7f", 4'b0000, 4'b0001);
    run_until("to_ff", 8'hFF, 4'b0000, 4'b0001);
    step();
    set_act(3'd6, 3'd5, 3'd6, 3'd7);
    check_all("apply_clamp", 4'b0000, 4'b0000);
    run_until("clamp_led", 8'd130, 4'b0000, 4'b0000);

    en = 1'b0;
    run_rows(10, 12);

    // mid-operation reset with ch1/ch2 busy
    rst = 1'b0;
    #1;
    mcnt = 8'd0;
    exp_tick = 1'b0;
    set_act(3'd7, 3'd7, 3'd7, 3'd7);
    check_all("async_rst", 4'b0000, 4'b0000);
    step();
    check_all("in_rst", 4'b0000, 4'b0000);
    rst = 1'b1;

    run_rows(13, 17);
    en = 1'b1;
    run_until("wait_wrap2", 8'hFF, 4'b0000, 4'b1111);
    step();
    set_act(3'd3, 3'd3, 3'd3, 3'd3);
    check_all("apply2", 4'b0000, 4'b0000);
    run_until("tail", 8'd20, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
